// File: rtl/hex_display_scan_if.sv
// hex_display_scan_if
//    Bundles the data, control and display signals of hex_display_scan.
//    master : the producer side (input stage / testbench); it drives the word and
//             the display controls and observes the display pins.
//    slave  : the display scanner; it consumes the word and controls and drives
//             an/seg/dp.
//    Signals:
//       usr_input [15:0]  hex word, [3:0] = digit 0
//       load              capture strobe for usr_input
//       blank_lz          blank leading-zero digits
//       blink_en  [3:0]   per-digit blink mask
//       dp_en     [3:0]   per-digit decimal point enable
//       an        [3:0]   digit enables
//       seg       [6:0]   segments {g,f,e,d,c,b,a}
//       dp                decimal point
interface hex_display_scan_if;
   logic [15:0] usr_input;
   logic        load;
   logic        blank_lz;
   logic [3:0]  blink_en;
   logic [3:0]  dp_en;
   logic [3:0]  an;
   logic [6:0]  seg;
   logic        dp;

   modport master (
      output usr_input, load, blank_lz, blink_en, dp_en,
      input  an, seg, dp
   );

   modport slave (
      input  usr_input, load, blank_lz, blink_en, dp_en,
      output an, seg, dp
   );
endinterface

// File: rtl/hex_display_scan.sv
// hex_display_scan
//    Captures a 16-bit hex word on a load strobe and scans it onto a 4-digit
//    multiplexed seven-segment display, digit 0 (LSB nibble) first. Each digit
//    slot lasts REFRESH_DIV clocks. Optional leading-zero blanking and per-digit
//    blinking (blink half-period = BLINK_DIV full scan frames).
//    Ports:
//       clk   system clock
//       rst   synchronous active-high reset; all display outputs off
//       bus   slave side of hex_display_scan_if (usr_input, load, blank_lz,
//             blink_en, dp_en in; an, seg, dp out, registered)
//    Parameters:
//       REFRESH_DIV  clocks per digit slot (>=2)
//       BLINK_DIV    scan frames per blink half-period (>=1)
//       ACTIVE_LOW   1: an/seg/dp are active-low; 0: active-high
module hex_display_scan #(
   parameter int unsigned REFRESH_DIV = 100000,
   parameter int unsigned BLINK_DIV   = 250,
   parameter bit          ACTIVE_LOW  = 1'b1
) (
   input logic              clk,
   input logic              rst,
   hex_display_scan_if.slave bus
);

   localparam int unsigned TW = $clog2(REFRESH_DIV);
   localparam int unsigned BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam logic [TW-1:0] TICK_LAST  = TW'(REFRESH_DIV - 1);
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

   // Output polarity masks: XOR with these turns "on = 1" into the pin level.
   localparam logic [3:0] AN_POL  = {4{ACTIVE_LOW}};
   localparam logic [6:0] SEG_POL = {7{ACTIVE_LOW}};

   logic [15:0]   disp_val_q,  disp_val_d;
   logic [TW-1:0] tick_q,      tick_d;
   logic [1:0]    digit_sel_q, digit_sel_d;
   logic [BW-1:0] blink_cnt_q, blink_cnt_d;
   logic          blink_ph_q,  blink_ph_d;
   logic [3:0]    an_q,        an_d;
   logic [6:0]    seg_q,       seg_d;
   logic          dp_q,        dp_d;

   logic          slot_end;
   logic          frame_end;
   logic [3:0]    nibble;
   logic          lz_zero;
   logic          dark;
   logic [3:0]    an_on;
   logic [6:0]    seg_on;
   logic          dp_on;

   // Active-high {g,f,e,d,c,b,a} pattern for one hex digit.
   function automatic logic [6:0] hex_decode(input logic [3:0] n);
      logic [6:0] s;
      case (n)
         4'h0: s = 7'b0111111;
         4'h1: s = 7'b0000110;
         4'h2: s = 7'b1011011;
         4'h3: s = 7'b1001111;
         4'h4: s = 7'b1100110;
         4'h5: s = 7'b1101101;
         4'h6: s = 7'b1111101;
         4'h7: s = 7'b0000111;
         4'h8: s = 7'b1111111;
         4'h9: s = 7'b1101111;
         4'hA: s = 7'b1110111;
         4'hB: s = 7'b1111100;
         4'hC: s = 7'b0111001;
         4'hD: s = 7'b1011110;
         4'hE: s = 7'b1111001;
         default: s = 7'b1110001;
      endcase
      return s;
   endfunction

   // Scan timing, blink phase and word capture.
   always_comb begin
      disp_val_d  = bus.load ? bus.usr_input : disp_val_q;
      tick_d      = tick_q;
      digit_sel_d = digit_sel_q;
      blink_cnt_d = blink_cnt_q;
      blink_ph_d  = blink_ph_q;

      slot_end  = (tick_q == TICK_LAST);
      frame_end = slot_end && (digit_sel_q == 2'd3);

      if (slot_end) begin
         tick_d      = '0;
         digit_sel_d = digit_sel_q + 2'd1;
      end else begin
         tick_d = tick_q + TW'(1);
      end

      if (frame_end) begin
         if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d = '0;
            blink_ph_d  = ~blink_ph_q;
         end else begin
            blink_cnt_d = blink_cnt_q + BW'(1);
         end
      end
   end

   // Display outputs for the currently selected digit; registered below, so the
   // pins follow the scan state one clock later.
   always_comb begin
      nibble = disp_val_q[{digit_sel_q, 2'b00} +: 4];

      // A digit is a leading zero when it and every more significant nibble is 0;
      // digit 0 is never blanked so an all-zero word still shows "0".
      case (digit_sel_q)
         2'd0:    lz_zero = 1'b0;
         2'd1:    lz_zero = (disp_val_q[15:4]  == 12'h000);
         2'd2:    lz_zero = (disp_val_q[15:8]  == 8'h00);
         default: lz_zero = (disp_val_q[15:12] == 4'h0);
      endcase

      dark = (bus.blank_lz && lz_zero) || (bus.blink_en[digit_sel_q] && blink_ph_q);

      an_on  = dark ? '0 : (4'b0001 << digit_sel_q);
      seg_on = dark ? '0 : hex_decode(nibble);
      dp_on  = !dark && bus.dp_en[digit_sel_q];

      an_d  = an_on  ^ AN_POL;
      seg_d = seg_on ^ SEG_POL;
      dp_d  = dp_on  ^ ACTIVE_LOW;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         disp_val_q  <= '0;
         tick_q      <= '0;
         digit_sel_q <= '0;
         blink_cnt_q <= '0;
         blink_ph_q  <= 1'b0;
         an_q        <= AN_POL;
         seg_q       <= SEG_POL;
         dp_q        <= ACTIVE_LOW;
      end else begin
         disp_val_q  <= disp_val_d;
         tick_q      <= tick_d;
         digit_sel_q <= digit_sel_d;
         blink_cnt_q <= blink_cnt_d;
         blink_ph_q  <= blink_ph_d;
         an_q        <= an_d;
         seg_q       <= seg_d;
         dp_q        <= dp_d;
      end
   end

   assign bus.an  = an_q;
   assign bus.seg = seg_q;
   assign bus.dp  = dp_q;

endmodule

// File: tb/tb_hex_display_scan.sv
// tb_hex_display_scan
//    Directed bench for hex_display_scan with REFRESH_DIV=4, BLINK_DIV=2,
//    ACTIVE_LOW=1. Edge numbering in the comments: E1 is the first rising edge
//    with rst low after a reset; pins after E(n) show digit ((n-1)/4) mod 4.
module tb_hex_display_scan;

   logic clk = 1'b0;
   logic rst;
   int   errors = 0;
   int   checks = 0;

   hex_display_scan_if bus ();

   hex_display_scan #(
      .REFRESH_DIV (4),
      .BLINK_DIV   (2),
      .ACTIVE_LOW  (1'b1)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Active-low segment patterns.
   localparam logic [6:0] S_OFF = 7'b1111111;
   localparam logic [6:0] S_0   = 7'b1000000;
   localparam logic [6:0] S_1   = 7'b1111001;
   localparam logic [6:0] S_2   = 7'b0100100;
   localparam logic [6:0] S_3   = 7'b0110000;
   localparam logic [6:0] S_4   = 7'b0011001;
   localparam logic [6:0] S_8   = 7'b0000000;
   localparam logic [6:0] S_A   = 7'b0001000;

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [3:0] an_e,
                      input logic [6:0] seg_e, input logic dp_e);
      checks++;
      assert (bus.an === an_e) else begin
         errors++;
         $error("FAIL %s an: got %b expected %b", tag, bus.an, an_e);
      end
      checks++;
      assert (bus.seg === seg_e) else begin
         errors++;
         $error("FAIL %s seg: got %b expected %b", tag, bus.seg, seg_e);
      end
      checks++;
      assert (bus.dp === dp_e) else begin
         errors++;
         $error("FAIL %s dp: got %b expected %b", tag, bus.dp, dp_e);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset with load high: nothing may be captured.
      rst = 1'b1;
      bus.load = 1'b1;
      bus.usr_input = 16'hFFFF;
      bus.blank_lz = 1'b0;
      bus.blink_en = 4'b0000;
      bus.dp_en = 4'b0000;
      tick(3);
      chk("reset_off", 4'b1111, S_OFF, 1'b1);

      // Scan of 16'h1234, dp on digit 2.
      rst = 1'b0;
      bus.usr_input = 16'h1234;
      bus.dp_en = 4'b0100;
      tick(1);                                   // E1: still shows cleared word
      chk("reset_cleared_val", 4'b1110, S_0, 1'b1);
      bus.load = 1'b0;
      tick(1); chk("scan_d0_first", 4'b1110, S_4, 1'b1);   // E2
      tick(2); chk("scan_d0_last",  4'b1110, S_4, 1'b1);   // E4
      tick(1); chk("scan_d1_first", 4'b1101, S_3, 1'b1);   // E5
      tick(3); chk("scan_d1_last",  4'b1101, S_3, 1'b1);   // E8
      tick(1); chk("scan_d2_dp",    4'b1011, S_2, 1'b0);   // E9
      tick(4); chk("scan_d3_first", 4'b0111, S_1, 1'b1);   // E13
      tick(3); chk("scan_d3_last",  4'b0111, S_1, 1'b1);   // E16
      tick(1); chk("scan_wrap_d0",  4'b1110, S_4, 1'b1);   // E17

      // Leading-zero blanking.
      rst = 1'b1;
      bus.dp_en = 4'b0000;
      tick(1);
      rst = 1'b0;
      bus.load = 1'b1;
      bus.usr_input = 16'h000A;
      bus.blank_lz = 1'b1;
      tick(1);                                   // E1
      bus.load = 1'b0;
      tick(1); chk("lz_d0_lit",   4'b1110, S_A,   1'b1);   // E2
      tick(3); chk("lz_d1_dark",  4'b1111, S_OFF, 1'b1);   // E5
      tick(4); chk("lz_d2_dark",  4'b1111, S_OFF, 1'b1);   // E9
      tick(4); chk("lz_d3_dark",  4'b1111, S_OFF, 1'b1);   // E13
      tick(4); chk("lz_d0_again", 4'b1110, S_A,   1'b1);   // E17
      bus.load = 1'b1;
      bus.usr_input = 16'h0000;
      tick(1);                                   // E18: capture
      bus.load = 1'b0;
      tick(1); chk("lz_all_zero", 4'b1110, S_0,   1'b1);   // E19

      // Blink on digit 0: dark during frames 2,3 (pins after E33..E64).
      rst = 1'b1;
      bus.blank_lz = 1'b0;
      tick(1);
      rst = 1'b0;
      bus.load = 1'b1;
      bus.usr_input = 16'h1234;
      bus.blink_en = 4'b0001;
      tick(1);                                   // E1
      bus.load = 1'b0;
      tick(1);  chk("blink_f0_d0_lit",  4'b1110, S_4,   1'b1);  // E2
      tick(3);  chk("blink_f0_d1",      4'b1101, S_3,   1'b1);  // E5
      tick(12); chk("blink_f1_d0_lit",  4'b1110, S_4,   1'b1);  // E17
      tick(16); chk("blink_f2_d0_dark", 4'b1111, S_OFF, 1'b1);  // E33
      tick(3);  chk("blink_f2_d0_end",  4'b1111, S_OFF, 1'b1);  // E36
      tick(1);  chk("blink_f2_d1_lit",  4'b1101, S_3,   1'b1);  // E37
      tick(12); chk("blink_f3_d0_dark", 4'b1111, S_OFF, 1'b1);  // E49
      tick(16); chk("blink_f4_d0_lit",  4'b1110, S_4,   1'b1);  // E65

      // Mid-scan load while digit 2 is on the pins.
      bus.blink_en = 4'b0000;
      tick(8); chk("midload_before",  4'b1011, S_2, 1'b1);  // E73
      bus.load = 1'b1;
      bus.usr_input = 16'h8888;
      tick(1); chk("midload_lag",     4'b1011, S_2, 1'b1);  // E74: capture edge
      bus.load = 1'b0;
      tick(1); chk("midload_visible", 4'b1011, S_8, 1'b1);  // E75
      tick(1); chk("midload_d2_end",  4'b1011, S_8, 1'b1);  // E76
      tick(1); chk("midload_d3",      4'b0111, S_8, 1'b1);  // E77

      // Reset while digit 3 is active; scan restarts at digit 0, tick 0.
      rst = 1'b1;
      tick(1); chk("midrst_off", 4'b1111, S_OFF, 1'b1);
      rst = 1'b0;
      tick(1); chk("midrst_d0_first", 4'b1110, S_0, 1'b1);  // E1
      tick(3); chk("midrst_d0_last",  4'b1110, S_0, 1'b1);  // E4
      tick(1); chk("midrst_d1",       4'b1101, S_0, 1'b1);  // E5

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
